control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//   Hardwired control sequencer for the bus-based datapath. Generates the per-step control strobes
//   that benches currently hand-drive: fetch T0-T2, then T3-T5 execute per opcode.
//   Sits beside datapath: reads IRregister, drives its *in/*out/Gr*/Read/IncPC controls.
//   Unlike fixed-sequence stimulus, it adds a parametrised memory wait, multi-opcode decode,
//   and halt/run control.
// PARAMETERS
//   MEM_WAIT  0  extra T1 cycles holding Read/MDRin for slow RAM (0..15)
//   OPW       5  opcode width; opcode = IRregister[31:32-OPW]
//   ALUOPW    4  width of AluOp output
// PORTS
//   Clock        in   1      single clock, all state on posedge
//   Reset        in   1      synchronous, active-high; overrides every other input
//   IRregister   in   32     current IR contents (opcode [31:27])
//   Stop         in   1      halt request; honoured at end of current instruction
//   Start        in   1      resume from HALTED
//   PCout,MARin,Read,MDRin,PCin,IncPC,MDRout,IRin  out 1 each  fetch strobes
//   Gra,Grb,Grc,Rin,Rout  out 1 each  register-select and register-file strobes
//   Yin,Zin,ZLOout,HIout,LOout,INPORTout,OUTPORTin  out 1 each  execute strobes
//   AluOp        out  ALUOPW  ALU function; valid only while Zin=1, else 0
//   Run          out  1      1 except in RESET_ST and HALTED
//   IllegalOp    out  1      one-cycle pulse in T3 on unknown opcode
// BEHAVIOUR
//   Moore FSM; outputs decode from the registered state only. One step per clock.
//   Unlisted strobes are 0 in every state.
//   States: RESET_ST, T0, T1, T2, T3, T4, T5, HALTED (+ STEP_WAIT, see CONFIGURATION).
//   Reset=1 at posedge -> RESET_ST. All outputs are 0, including Run.
//   Next state from RESET_ST is T0 once Reset=0.
//   T0: PCout,MARin.
//   T1: Read,MDRin held for MEM_WAIT+1 cycles, counted by a wait counter cleared on T1 entry.
//       PCin,IncPC assert only in the last T1 cycle, so PC increments exactly once.
//   T2: MDRout,IRin -> T3. Decode uses IRregister in T3.
//   ADD/SUB/AND/OR (00011/00100/01010/01011):
//       T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,AluOp; T5 Gra,Rin,ZLOout -> T0.
//   MFHI 11000: T3 Gra,Rin,HIout -> T0.   MFLO 11001: T3 Gra,Rin,LOout -> T0.
//   IN 10110: T3 Gra,Rin,INPORTout -> T0.  OUT 10111: T3 Gra,Rout,OUTPORTin -> T0.
//   JR 10100: T3 Gra,Rout,PCin -> T0.
//   NOP 11010: T3 no strobes -> T0.       HALT 11011: T3 no strobes -> HALTED.
//   Other opcodes: T3 IllegalOp=1, no other strobes -> T0.
//   Stop: latched into stop_pend in any non-HALTED state.
//       On the last execute step, stop_pend=1 sends the FSM to HALTED instead of T0.
//       stop_pend clears on HALTED entry.
//   HALTED: all strobes 0, Run=0. Start=1 & Stop=0 -> T0. Stop=1 wins over Start.
//   Latency: single-step-execute opcodes take 4+MEM_WAIT cycles; ALU opcodes take 6+MEM_WAIT.
//   Reset mid-instruction: the instruction is abandoned, with no further strobes.
//       stop_pend and the wait counter clear.
// CONFIGURATION
//   SINGLE_STEP_EN defined: adds input Step (1).
//       Each completed instruction enters STEP_WAIT: all strobes 0, Run=1.
//       A Step=1 cycle -> T0. Stop pending takes priority -> HALTED.
//   Undefined: no Step port, no STEP_WAIT; instructions run back-to-back.
// STRUCTURE
//   Package control_pkg: opcode localparams, state encoding, ALU op codes
//       (ADD=0, SUB=1, AND=2, OR=3), MEM_WAIT counter width.
//   Sub-module control_decode: combinational opcode -> {class, AluOp, illegal}.
//   The FSM and wait counter stay in control_unit.
// TESTING
//   1. Reset 2 cycles, IR=0xC2000000 (mfhi R4), MEM_WAIT=0
//      -> T0..T3 on cycles 1-4; Gra,Rin,HIout only in cycle 4; T0 again on cycle 5.
//   2. MEM_WAIT=2, ADD opcode
//      -> Read/MDRin high 3 cycles, PCin/IncPC high 1 cycle (the 3rd); Zin with AluOp=0 in T4.
//   3. HALT opcode -> Run=0 from cycle after T3. Start=1 one cycle -> T0 on the following cycle.
//   4. Stop pulsed during T1 of OUT -> OUTPORTin still pulses in T3, then HALTED, no T0.
//   5. Reset=1 during T4 of SUB -> next cycle all outputs 0, Run=0.
//      No ZLOout is ever issued; T0 follows Reset release.
//   6. Opcode 11111 -> IllegalOp=1 exactly one cycle in T3, then T0.
//      With SINGLE_STEP_EN: waits in STEP_WAIT until Step=1.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// FSM state encoding, instruction classes, ALU function codes and the
// width of the memory-wait counter.
// Optional build macro: SINGLE_STEP_EN adds the STEP_WAIT state.
package control_pkg;

  // Holds MEM_WAIT values 0..15.
  localparam int unsigned WAIT_W = 4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    RESET_ST,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    HALTED
`ifdef SINGLE_STEP_EN
    , STEP_WAIT
`endif
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_MFHI,
    CLS_MFLO,
    CLS_IN,
    CLS_OUT,
    CLS_JR,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder for control_unit.
// Ports:
//   opcode   in   OPW     instruction opcode field
//   op_class out          execution class of the opcode
//   alu_op   out  ALUOPW  ALU function for ALU-class opcodes, else 0
//   illegal  out  1       opcode not recognised
module control_decode import control_pkg::*; #(
  parameter int unsigned OPW    = 5,
  parameter int unsigned ALUOPW = 4
) (
  input  logic [OPW-1:0]    opcode,
  output op_class_t         op_class,
  output logic [ALUOPW-1:0] alu_op,
  output logic              illegal
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = '0;
    illegal  = 1'b0;
    case (opcode)
      OPW'(OP_ADD):  begin op_class = CLS_ALU; alu_op = ALUOPW'(ALU_ADD); end
      OPW'(OP_SUB):  begin op_class = CLS_ALU; alu_op = ALUOPW'(ALU_SUB); end
      OPW'(OP_AND):  begin op_class = CLS_ALU; alu_op = ALUOPW'(ALU_AND); end
      OPW'(OP_OR):   begin op_class = CLS_ALU; alu_op = ALUOPW'(ALU_OR);  end
      OPW'(OP_MFHI): op_class = CLS_MFHI;
      OPW'(OP_MFLO): op_class = CLS_MFLO;
      OPW'(OP_IN):   op_class = CLS_IN;
      OPW'(OP_OUT):  op_class = CLS_OUT;
      OPW'(OP_JR):   op_class = CLS_JR;
      OPW'(OP_NOP):  op_class = CLS_NOP;
      OPW'(OP_HALT): op_class = CLS_HALT;
      default:       illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the bus-based datapath. Fetch runs T0-T2
// (T1 stretched by MEM_WAIT cycles for slow memory), execute runs T3-T5 per
// opcode. Supports halt/resume via Stop/Start.
// Optional build macro: SINGLE_STEP_EN adds input Step and a STEP_WAIT state
// entered after every completed instruction.
// Ports:
//   Clock, Reset (sync, active-high), IRregister[31:0], Stop, Start, [Step]
//   Fetch strobes:    PCout MARin Read MDRin PCin IncPC MDRout IRin
//   Register strobes: Gra Grb Grc Rin Rout
//   Execute strobes:  Yin Zin ZLOout HIout LOout INPORTout OUTPORTin
//   AluOp[ALUOPW-1:0] (non-zero only while Zin), Run, IllegalOp
module control_unit import control_pkg::*; #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned OPW      = 5,
  parameter int unsigned ALUOPW   = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [31:0]       IRregister,
  input  logic              Stop,
  input  logic              Start,
`ifdef SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic              PCout,
  output logic              MARin,
  output logic              Read,
  output logic              MDRin,
  output logic              PCin,
  output logic              IncPC,
  output logic              MDRout,
  output logic              IRin,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic              Yin,
  output logic              Zin,
  output logic              ZLOout,
  output logic              HIout,
  output logic              LOout,
  output logic              INPORTout,
  output logic              OUTPORTin,
  output logic [ALUOPW-1:0] AluOp,
  output logic              Run,
  output logic              IllegalOp
);

  state_t            state, state_nxt, done_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_done;
  logic              stop_pend;
  op_class_t         op_class;
  logic [ALUOPW-1:0] alu_op;
  logic              illegal;
  logic              unused_ir;

  assign unused_ir = ^IRregister[31-OPW:0];

  control_decode #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW)
  ) u_decode (
    .opcode   (IRregister[31:32-OPW]),
    .op_class (op_class),
    .alu_op   (alu_op),
    .illegal  (illegal)
  );

  assign wait_done = (wait_cnt == WAIT_W'(MEM_WAIT));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= RESET_ST;
      wait_cnt  <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter only runs while stretching T1; zero everywhere else so the
      // next T1 entry always starts from 0.
      wait_cnt <= (state == T1 && !wait_done) ? wait_cnt + WAIT_W'(1) : '0;
      if (state_nxt == HALTED)
        stop_pend <= 1'b0;
      else if (state != HALTED)
        stop_pend <= stop_pend | Stop;
    end
  end

  always_comb begin
    PCout     = 1'b0;
    MARin     = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    ZLOout    = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    INPORTout = 1'b0;
    OUTPORTin = 1'b0;
    AluOp     = '0;
    IllegalOp = 1'b0;
    Run       = (state != RESET_ST) && (state != HALTED);
    state_nxt = state;

    // Destination after the last execute step of an instruction.
`ifdef SINGLE_STEP_EN
    done_nxt = stop_pend ? HALTED : STEP_WAIT;
`else
    done_nxt = stop_pend ? HALTED : T0;
`endif

    case (state)
      RESET_ST: state_nxt = T0;
      T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        state_nxt = T1;
      end
      T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (wait_done) begin
          PCin      = 1'b1;
          IncPC     = 1'b1;
          state_nxt = T2;
        end
      end
      T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        state_nxt = done_nxt;
        case (op_class)
          CLS_ALU:  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_nxt = T4; end
          CLS_MFHI: begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
          CLS_MFLO: begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
          CLS_IN:   begin Gra = 1'b1; Rin = 1'b1; INPORTout = 1'b1; end
          CLS_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
          CLS_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CLS_NOP:  ;
          CLS_HALT: state_nxt = HALTED;
          default:  IllegalOp = illegal;
        endcase
      end
      T4: begin
        Grc       = 1'b1;
        Rout      = 1'b1;
        Zin       = 1'b1;
        AluOp     = alu_op;
        state_nxt = T5;
      end
      T5: begin
        Gra       = 1'b1;
        Rin       = 1'b1;
        ZLOout    = 1'b1;
        state_nxt = done_nxt;
      end
      HALTED: begin
        if (!Stop && Start)
          state_nxt = T0;
      end
`ifdef SINGLE_STEP_EN
      STEP_WAIT: begin
        if (stop_pend)
          state_nxt = HALTED;
        else if (Step)
          state_nxt = T0;
      end
`endif
      default: state_nxt = RESET_ST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  typedef struct packed {
    logic       pcout, marin, read, mdrin, pcin, incpc, mdrout, irin;
    logic       gra, grb, grc, rin, rout;
    logic       yin, zin, zloout, hiout, loout, inportout, outportin;
    logic [3:0] aluop;
    logic       run, illegal;
  } ctl_t;

  localparam int M_RESET = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_STEP  = 3;
`ifdef SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset, Stop, Start, Step;
  logic [31:0] ir [2];
  ctl_t        obs [2];

  always #5 Clock = ~Clock;

  // Two instances: MEM_WAIT = 0 and MEM_WAIT = 2.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pcout, marin, read, mdrin, pcin, incpc, mdrout, irin;
    logic gra, grb, grc, rin, rout;
    logic yin, zin, zloout, hiout, loout, inportout, outportin;
    logic [3:0] aluop;
    logic run, illegal;

    control_unit #(.MEM_WAIT(g * 2), .OPW(5), .ALUOPW(4)) u_dut (
      .Clock(Clock), .Reset(Reset), .IRregister(ir[g]), .Stop(Stop), .Start(Start),
`ifdef SINGLE_STEP_EN
      .Step(Step),
`endif
      .PCout(pcout), .MARin(marin), .Read(read), .MDRin(mdrin), .PCin(pcin),
      .IncPC(incpc), .MDRout(mdrout), .IRin(irin), .Gra(gra), .Grb(grb), .Grc(grc),
      .Rin(rin), .Rout(rout), .Yin(yin), .Zin(zin), .ZLOout(zloout), .HIout(hiout),
      .LOout(loout), .INPORTout(inportout), .OUTPORTin(outportin), .AluOp(aluop),
      .Run(run), .IllegalOp(illegal)
    );

    assign obs[g] = {pcout, marin, read, mdrin, pcin, incpc, mdrout, irin,
                     gra, grb, grc, rin, rout,
                     yin, zin, zloout, hiout, loout, inportout, outportin,
                     aluop, run, illegal};
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each instruction is expanded into its list of per-cycle
  // strobe words when it starts; the model then walks that list.
  ctl_t        sched [2][24];
  int          len [2], pos [2], mode [2], fidx [2];
  bit          pend [2], halt_op [2];
  logic [31:0] next_ir [2];
  logic [31:0] fq [$];

  task automatic push(input int d, input ctl_t w);
    sched[d][len[d]] = w;
    len[d]++;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] op;
    case ($urandom_range(0, 13))
      0: op = 5'b00011;  1: op = 5'b00100;  2: op = 5'b01010;  3: op = 5'b01011;
      4: op = 5'b11000;  5: op = 5'b11001;  6: op = 5'b10110;  7: op = 5'b10111;
      8: op = 5'b10100;  9: op = 5'b11010;  10: op = 5'b11011;
      default: op = 5'($urandom);
    endcase
    return {op, 27'($urandom)};
  endfunction

  task automatic start_instr(input int d);
    logic [31:0] v;
    logic [4:0]  op;
    ctl_t        w;
    if (fidx[d] < fq.size()) begin
      v = fq[fidx[d]];
      fidx[d]++;
    end else
      v = rand_ir();
    next_ir[d] = v;
    op         = v[31:27];
    len[d]     = 0;
    pos[d]     = 0;
    halt_op[d] = 1'b0;
    mode[d]    = M_RUN;
    w = '0; w.run = 1; w.pcout = 1; w.marin = 1; push(d, w);
    for (int i = 0; i < d * 2; i++) begin
      w = '0; w.run = 1; w.read = 1; w.mdrin = 1; push(d, w);
    end
    w = '0; w.run = 1; w.read = 1; w.mdrin = 1; w.pcin = 1; w.incpc = 1; push(d, w);
    w = '0; w.run = 1; w.mdrout = 1; w.irin = 1; push(d, w);
    w = '0; w.run = 1;
    case (op)
      5'b00011, 5'b00100, 5'b01010, 5'b01011: begin
        w.grb = 1; w.rout = 1; w.yin = 1; push(d, w);
        w = '0; w.run = 1; w.grc = 1; w.rout = 1; w.zin = 1;
        w.aluop = (op == 5'b00011) ? 4'd0 : (op == 5'b00100) ? 4'd1 :
                  (op == 5'b01010) ? 4'd2 : 4'd3;
        push(d, w);
        w = '0; w.run = 1; w.gra = 1; w.rin = 1; w.zloout = 1; push(d, w);
      end
      5'b11000: begin w.gra = 1; w.rin = 1; w.hiout = 1; push(d, w); end
      5'b11001: begin w.gra = 1; w.rin = 1; w.loout = 1; push(d, w); end
      5'b10110: begin w.gra = 1; w.rin = 1; w.inportout = 1; push(d, w); end
      5'b10111: begin w.gra = 1; w.rout = 1; w.outportin = 1; push(d, w); end
      5'b10100: begin w.gra = 1; w.rout = 1; w.pcin = 1; push(d, w); end
      5'b11010: push(d, w);
      5'b11011: begin halt_op[d] = 1'b1; push(d, w); end
      default:  begin w.illegal = 1; push(d, w); end
    endcase
  endtask

  task automatic model_step(input int d);
    bit p;
    p = pend[d];
    if (Reset) begin
      mode[d] = M_RESET;
      pend[d] = 1'b0;
      return;
    end
    case (mode[d])
      M_RESET: begin
        start_instr(d);
        pend[d] = p | Stop;
      end
      M_RUN: begin
        if (pos[d] == len[d] - 1) begin
          if (halt_op[d] || p) begin
            mode[d] = M_HALT;
            pend[d] = 1'b0;
          end else begin
            if (STEP_EN) mode[d] = M_STEP;
            else start_instr(d);
            pend[d] = p | Stop;
          end
        end else begin
          pos[d]++;
          pend[d] = p | Stop;
        end
      end
      M_HALT: if (!Stop && Start) start_instr(d);
      default: begin
        if (p) begin
          mode[d] = M_HALT;
          pend[d] = 1'b0;
        end else begin
          if (Step) start_instr(d);
          pend[d] = p | Stop;
        end
      end
    endcase
  endtask

  function automatic ctl_t expected(input int d);
    ctl_t w;
    w = '0;
    case (mode[d])
      M_RUN:  w = sched[d][pos[d]];
      M_STEP: w.run = 1;
      default: ;
    endcase
    return w;
  endfunction

  task automatic cyc(input bit r, input bit sp, input bit st, input bit sw);
    Reset = r; Stop = sp; Start = st; Step = sw;
    @(posedge Clock);
    for (int d = 0; d < 2; d++) model_step(d);
    @(negedge Clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut_wait%0d", d * 2), 32'(obs[d]), 32'(expected(d)));
      ir[d] = next_ir[d];
    end
  endtask

  initial begin
    Reset = 1; Stop = 0; Start = 0; Step = 0;
    for (int d = 0; d < 2; d++) begin
      ir[d] = '0; next_ir[d] = '0; mode[d] = M_RESET; pend[d] = 0;
      fidx[d] = 0; len[d] = 0; pos[d] = 0; halt_op[d] = 0;
    end
    // mfhi, add, halt, out, sub, illegal
    fq = '{32'hC2000000, 32'h18000000, 32'hD8000000, 32'hB8000000,
           32'h20000000, 32'hF8000000};

    repeat (2) cyc(1, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 1);          // mfhi, add, halt -> halted
    cyc(0, 0, 1, 1);                      // resume
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);                      // stop pulse during fetch of OUT
    repeat (12) cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 1);                      // Stop wins over Start
    cyc(0, 0, 1, 1);                      // resume into SUB
    repeat (4) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);                      // reset during T4 of SUB (wait-0 instance)
    repeat (20) cyc(0, 0, 0, 1);          // illegal opcode, then random program

    repeat (3000)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
